// File: rtl/mp_pkg.sv
// Shared definitions for the instruction fetch slice: sizes, instruction
// field layout, opcode validity table and the fetch FSM state type.
package mp_pkg;

  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int XLEN    = 32;
  localparam int LEN_W   = 6;
  localparam int MAX_LEN = 32;
  localparam int CNT_W   = 8;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 6;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_LSB = 11;
  localparam int DST_LSB  = 16;
  localparam int REG_W    = 5;

  // Bit n set means opcode n is valid: 1,4,5,6,7,8,9,11,12,13,14.
  // Opcodes 16 and above are never valid.
  localparam logic [15:0] VALID_OPC_MASK = 16'h7BF2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opc_field(input logic [XLEN-1:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/opcode_check.sv
// Flags whether a 6-bit opcode belongs to the implemented instruction set.
module opcode_check
  import mp_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             valid
);

  assign valid = (opcode[5:4] == 2'b00) && VALID_OPC_MASK[opcode[3:0]];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues prog_len words from a local instruction
// memory over a valid/ready handshake, optionally looping, and counts
// issued instructions with invalid opcodes.
module instr_fetch #(
  parameter int DEPTH = mp_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [5:0]              prog_len,
  input  logic                    loop_en,
  input  logic                    load_en,
  input  logic [mp_pkg::AW-1:0]   load_addr,
  input  logic [31:0]             load_data,
  output logic [31:0]             instr_out,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [mp_pkg::AW-1:0]   pc,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              invalid_cnt
);
  import mp_pkg::*;

  logic [XLEN-1:0]  mem [DEPTH];
  fetch_state_e     state_q, state_d;
  logic [LEN_W-1:0] len_q, len_start;
  logic             accept_start, handshake, last, opc_ok;

  assign len_start    = (prog_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : prog_len;
  // A write in the same cycle as start wins; the start is dropped.
  assign accept_start = (state_q == S_IDLE) && start && !load_en && !stop;
  assign handshake    = instr_valid && instr_ready;
  assign last         = ({1'b0, pc} == (len_q - LEN_W'(1)));

  assign instr_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);

  opcode_check u_opcode_check (
    .opcode (opc_field(instr_out)),
    .valid  (opc_ok)
  );

  // NOTE: the memory has no reset so it keeps its program across rst_n and
  // maps onto plain RAM; writes are only honoured while idle.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == S_IDLE)) begin
      mem[load_addr] <= load_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          state_d = (len_start == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (handshake) begin
          state_d = (last && !loop_en) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pc          <= '0;
      instr_out   <= '0;
      invalid_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (!stop) begin
        if (accept_start) begin
          len_q       <= len_start;
          pc          <= '0;
          invalid_cnt <= '0;
        end
        if (state_q == S_FETCH) begin
          instr_out <= mem[pc];
        end
        if ((state_q == S_ISSUE) && handshake) begin
          if (!last) begin
            pc <= pc + AW'(1);
          end else if (loop_en) begin
            pc <= '0;
          end
          if (!opc_ok && (invalid_cnt != '1)) begin
            invalid_cnt <= invalid_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set the number of instruction memory words; AW = 5 SHALL be the pc width.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin issuing from address 0.
REQ-005 stop  input  1  abort request, takes effect in any state.
REQ-006 prog_len  input  6  number of instructions to issue; valid range 0..32.
REQ-007 loop_en  input  1  when high, restart at address 0 after the last instruction.
REQ-008 load_en  input  1  instruction memory write strobe.
REQ-009 load_addr  input  5  instruction memory write address.
REQ-010 load_data  input  32  instruction memory write data.
REQ-011 instr_out  output  32  instruction to the downstream core; bits [5:0] are the opcode, [10:6] src1, [15:11] src2, [20:16] dst.
REQ-012 instr_valid  output  1  instr_out holds an issuable instruction.
REQ-013 instr_ready  input  1  downstream core accepts instr_out.
REQ-014 pc  output  5  address of the instruction currently fetched or presented.
REQ-015 busy  output  1  high in FETCH and ISSUE.
REQ-016 done  output  1  one-cycle pulse marking program completion.
REQ-017 invalid_cnt  output  8  count of issued instructions whose opcode is invalid.

Function
REQ-018 The FSM SHALL have four states: IDLE, FETCH, ISSUE and DONE.
REQ-019 IDLE: on start, go to FETCH with pc=0 and invalid_cnt=0; if prog_len=0, go to DONE instead.
REQ-020 FETCH: perform a one-cycle synchronous memory read of mem[pc], latch the result into instr_out, then go to ISSUE.
REQ-021 ISSUE: hold instr_valid=1 and keep instr_out and pc stable until instr_valid and instr_ready are both high in the same cycle (the handshake).
REQ-022 Latency: start at cycle N SHALL give instr_valid=1 at N+2; a handshake at cycle M SHALL give the next instr_valid at M+2 (one instruction per 2 cycles maximum).
REQ-023 On handshake when pc < len-1: pc SHALL increment by 1 and the FSM SHALL go to FETCH.
REQ-024 On handshake when pc = len-1 and loop_en=1: pc SHALL wrap to 0 and the FSM SHALL go to FETCH.
REQ-025 On handshake when pc = len-1 and loop_en=0: the FSM SHALL go to DONE.
REQ-026 len SHALL equal prog_len clamped to 32 (values above 32 count as 32) and SHALL be captured at start.
REQ-027 DONE: assert done for one cycle, then go to IDLE.
REQ-028 Valid opcodes SHALL be 1, 4, 5, 6, 7, 8, 9, 11, 12, 13 and 14; all others are invalid: 0, 2, 3, 10, 15 and anything ≥16.
REQ-029 invalid_cnt SHALL increment on each handshake of an invalid-opcode instruction and saturate at 255; such instructions are still issued.
REQ-030 stop SHALL force IDLE on the next edge from any state, drop instr_valid, and suppress done; stop has priority over start and handshake.
REQ-031 load_en SHALL write mem[load_addr] only in IDLE and SHALL be ignored otherwise.
REQ-032 If load_en and start are high in the same IDLE cycle, the write SHALL occur and start SHALL be ignored.
REQ-033 A start while not in IDLE SHALL be ignored.

Reset
REQ-034 On rst_n=0 the block SHALL asynchronously enter IDLE with pc=0, instr_out=0, instr_valid=0, busy=0, done=0 and invalid_cnt=0.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Reset asserted mid-ISSUE SHALL drop instr_valid immediately, with no done pulse.

Structure
REQ-037 The shared package mp_pkg SHALL hold the opcode constants, the opcode valid/invalid definition, the instruction field positions, and DEPTH/AW.
REQ-038 The opcode validity check SHALL be a sub-module, opcode_check (6-bit opcode in, 1-bit valid out), reused by the core.
REQ-039 The memory SHALL be an inferred array inside instr_fetch.

Verification
REQ-040 Load 3 words {0x00010846, 0x00020C89, 0x0003104B}, prog_len=3, ready tied high, start -> three valid beats at cycles +2, +4, +6 with pc 0, 1, 2; done at +7; invalid_cnt=0.
REQ-041 Backpressure: hold ready=0 for 5 cycles during beat 0 -> instr_out and pc stay stable and instr_valid stays high; the beat is accepted when ready rises.
REQ-042 Opcodes {0x00, 0x0A, 0x3F, 0x06}, prog_len=4 -> all 4 are issued; invalid_cnt=3.
REQ-043 loop_en=1, prog_len=2 -> pc sequence 0, 1, 0, 1, ... with no done; then stop -> instr_valid=0 the next cycle, no done pulse.
REQ-044 prog_len=0 -> done one cycle after start with no beats; prog_len=40 -> exactly 32 beats.
REQ-045 rst_n pulsed low mid-ISSUE -> all outputs zero asynchronously; memory retained, so a re-run reproduces the same instructions.
